btb_set_assoc: RTL and testbench
================================

// Module: btb_set_assoc
// PURPOSE
//   Parametrised N-way set-associative Branch Target Buffer with n-bit saturating counters.
//   Sits in the IF stage. Lookup is combinational and runs in parallel with the fetch.
//   Updates come synchronously from EX on branch/jump resolution.
//   Adds per-set round-robin replacement and a sweep state machine for reset/flush invalidation.
// PARAMETERS
//   XLEN           32  address/target width
//   INDEX_BITS     5   set index bits; SETS = 2**INDEX_BITS, index = PC[INDEX_BITS+1:2]
//   WAYS           2   associativity, power of two, 1..8
//   COUNTER_BITS   2   saturating counter width, 2..4
// PORTS
//   i_clk               in   1     clock
//   i_rst               in   1     synchronous active-high reset
//   i_flush             in   1     pulse: invalidate all entries (e.g. fence.i)
//   o_busy              out  1     sweep in progress; lookups miss, updates dropped
//   i_pc                in   XLEN  IF-stage PC for lookup
//   o_btb_hit           out  1     valid tag match in some way
//   o_predicted_taken   out  1     hit && counter MSB set
//   o_predicted_target  out  XLEN  target from hit way (0 on miss)
//   i_update            in   1     EX resolution strobe
//   i_update_pc         in   XLEN  PC of resolved branch
//   i_update_target     in   XLEN  resolved target
//   i_update_taken      in   1     resolved outcome
//   o_perf_lookups/o_perf_hits/o_perf_updates  out 32  only with BTB_PERF_EN (see CONFIGURATION)
// BEHAVIOUR
//   - One clock (i_clk). Reset is synchronous, active-high (i_rst).
//   - Tag = {PC[XLEN-1:INDEX_BITS+2], PC[1]}; TagBits = XLEN-INDEX_BITS-1.
//   - Valid, tag, target and counter are held per way in LUTRAM (sdp_dist_ram).
//     Replacement pointers are held in FFs.
//   - FSM IDLE/SWEEP:
//       i_rst -> SWEEP, sweep_idx=0.
//       i_flush in IDLE -> SWEEP next cycle.
//       In SWEEP: write valid=0 to all ways of set sweep_idx; sweep_idx++.
//       At sweep_idx==SETS-1 -> IDLE.
//       Sweep lasts exactly SETS cycles.
//       i_flush during SWEEP restarts at 0. i_rst mid-sweep restarts at 0.
//   - Reset values: o_busy=1 in the cycle after reset, and o_busy=1 throughout SWEEP.
//     o_btb_hit=0, o_predicted_taken=0, o_predicted_target=0, all RR pointers=0.
//   - Lookup, 0-cycle latency:
//       hit_w = valid[w] && tag[w]==lookup_tag.
//       At most one way hits (invariant kept by update).
//       Hit outputs are forced to 0 while o_busy.
//   - Update, 1 cycle, ignored while o_busy. Way selection priority:
//       (1) the tag-matching valid way;
//       (2) the lowest-index invalid way;
//       (3) the set's RR pointer, which then increments mod WAYS.
//     The RR pointer advances only on allocation case (3).
//   - Update writes: valid=1, tag, target, counter.
//   - Counter rule on a matching way:
//       taken -> saturating +1 (max 2**CB-1)
//       not taken -> saturating -1 (min 0)
//   - Counter rule on a new allocation:
//       taken -> weakly taken = 1<<(CB-1)
//       not taken -> weakly not-taken = (1<<(CB-1))-1
//   - Lookup and update to the same set in the same cycle: the lookup sees pre-update contents.
//   - Back-to-back updates to the same entry must read the just-written value.
//     This is guaranteed because LUTRAM writes land at the clock edge.
// CONFIGURATION
//   - BTB_PERF_EN defined: three 32-bit wrapping counters, reset to 0, and none count while busy.
//       o_perf_lookups increments every non-busy cycle.
//       o_perf_hits increments on o_btb_hit.
//       o_perf_updates increments on accepted i_update.
//   - Undefined: the perf ports are absent and no counter logic is built.
// STRUCTURE
//   - Shared package: btb_state_e {IDLE,SWEEP} typedef, and counter init/saturate functions
//     parametrised by COUNTER_BITS.
//   - Sub-module btb_way: one way's tag/target/counter/valid LUTRAMs (lookup and update read ports).
//     Instantiated WAYS times via generate.
//   - The top level holds the FSM, the hit/victim select and the RR pointer array.
// TESTING
//   1. Reset with WAYS=2, SETS=32: o_busy=1 for exactly 32 cycles, then 0.
//      Lookup of any PC during that time gives hit=0.
//   2. Update PC=0x100, target=0x200, taken. Next cycle lookup 0x100 -> hit=1, taken=1, target=0x200.
//      Lookup 0x102 -> hit=0.
//   3. Three taken updates then two not-taken updates to 0x100 (CB=2):
//      counters 10,11,11,10,01; prediction taken,taken,taken,taken,not-taken.
//   4. Allocate 0x100, then 0x1100, then 0x2100 (same set).
//      0x2100 evicts way0 (0x100); 0x1100 stays resident.
//   5. i_flush mid-run: the following 32 cycles are busy and updates are dropped.
//      Afterwards a lookup of 0x100 misses. i_rst at sweep cycle 10 restarts the 32-cycle count.
//   6. BTB_PERF_EN: 10 lookups with 4 hits and 3 updates -> perf = 10/4/3. After reset, all 0.

Source files
------------

// File: rtl/btb_set_assoc_pkg.sv
// btb_set_assoc_pkg: shared FSM state type and saturating-counter helpers for the BTB
//   btb_state_e : IDLE / SWEEP invalidation state
//   ctr_init    : counter value for a freshly allocated entry (weakly taken / weakly not-taken)
//   ctr_sat     : saturating increment (taken) or decrement (not taken)
//   Counters are carried as 4 bits, the widest COUNTER_BITS allowed; callers truncate.
package btb_set_assoc_pkg;

   typedef enum logic {IDLE, SWEEP} btb_state_e;

   function automatic logic [3:0] ctr_init(input logic taken, input int cb);
      return taken ? 4'(1 << (cb - 1)) : 4'((1 << (cb - 1)) - 1);
   endfunction

   function automatic logic [3:0] ctr_sat(input logic [3:0] c, input logic taken, input int cb);
      logic [3:0] max_c;
      max_c = 4'((1 << cb) - 1);
      return taken ? ((c == max_c) ? c : 4'(c + 4'd1)) : ((c == 4'd0) ? c : 4'(c - 4'd1));
   endfunction

endpackage

// File: rtl/btb_set_assoc_way.sv
// btb_set_assoc_way: one BTB way -- valid/tag/target/counter held in distributed RAM
//   i_clk                       clock
//   i_lk_idx / o_lk_*           asynchronous lookup read port (valid, tag, target, counter)
//   i_up_idx / o_up_*           asynchronous update-side read port (valid, tag, counter)
//   i_we, i_w_idx, i_w_*        single synchronous write port (sweep invalidation or update)
//   No reset: contents are cleared by the top-level sweep after reset.
module btb_set_assoc_way #(
   parameter int XLEN         = 32,
   parameter int INDEX_BITS   = 5,
   parameter int TAG_BITS     = 26,
   parameter int COUNTER_BITS = 2
) (
   input  logic                    i_clk,
   input  logic [INDEX_BITS-1:0]   i_lk_idx,
   output logic                    o_lk_valid,
   output logic [TAG_BITS-1:0]     o_lk_tag,
   output logic [XLEN-1:0]         o_lk_target,
   output logic [COUNTER_BITS-1:0] o_lk_ctr,
   input  logic [INDEX_BITS-1:0]   i_up_idx,
   output logic                    o_up_valid,
   output logic [TAG_BITS-1:0]     o_up_tag,
   output logic [COUNTER_BITS-1:0] o_up_ctr,
   input  logic                    i_we,
   input  logic [INDEX_BITS-1:0]   i_w_idx,
   input  logic                    i_w_valid,
   input  logic [TAG_BITS-1:0]     i_w_tag,
   input  logic [XLEN-1:0]         i_w_target,
   input  logic [COUNTER_BITS-1:0] i_w_ctr
);
   localparam int SETS = 1 << INDEX_BITS;

   logic                    valid_q  [SETS];
   logic [TAG_BITS-1:0]     tag_q    [SETS];
   logic [XLEN-1:0]         target_q [SETS];
   logic [COUNTER_BITS-1:0] ctr_q    [SETS];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         valid_q[i_w_idx]  <= i_w_valid;
         tag_q[i_w_idx]    <= i_w_tag;
         target_q[i_w_idx] <= i_w_target;
         ctr_q[i_w_idx]    <= i_w_ctr;
      end
   end

   assign o_lk_valid  = valid_q[i_lk_idx];
   assign o_lk_tag    = tag_q[i_lk_idx];
   assign o_lk_target = target_q[i_lk_idx];
   assign o_lk_ctr    = ctr_q[i_lk_idx];
   assign o_up_valid  = valid_q[i_up_idx];
   assign o_up_tag    = tag_q[i_up_idx];
   assign o_up_ctr    = ctr_q[i_up_idx];

endmodule

// File: rtl/btb_set_assoc.sv
// btb_set_assoc: N-way set-associative branch target buffer with saturating counters
//   i_clk, i_rst             clock, synchronous active-high reset (starts an invalidation sweep)
//   i_flush                  pulse: invalidate all entries via a SETS-cycle sweep
//   o_busy                   sweep in progress; lookups miss, updates dropped
//   i_pc                     IF-stage lookup PC (combinational lookup)
//   o_btb_hit, o_predicted_taken, o_predicted_target   lookup result
//   i_update, i_update_pc, i_update_target, i_update_taken   EX resolution (written at clock edge)
//   o_perf_lookups/hits/updates   32-bit counters, present only when BTB_PERF_EN is defined
//   Optional feature macro: BTB_PERF_EN
module btb_set_assoc
   import btb_set_assoc_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int INDEX_BITS   = 5,
   parameter int WAYS         = 2,
   parameter int COUNTER_BITS = 2
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_flush,
   output logic            o_busy,
   input  logic [XLEN-1:0] i_pc,
   output logic            o_btb_hit,
   output logic            o_predicted_taken,
   output logic [XLEN-1:0] o_predicted_target,
   input  logic            i_update,
   input  logic [XLEN-1:0] i_update_pc,
   input  logic [XLEN-1:0] i_update_target,
   input  logic            i_update_taken
`ifdef BTB_PERF_EN
   ,
   output logic [31:0]     o_perf_lookups,
   output logic [31:0]     o_perf_hits,
   output logic [31:0]     o_perf_updates
`endif
);
   localparam int SETS = 1 << INDEX_BITS;
   localparam int TB   = XLEN - INDEX_BITS - 1;
   localparam int WB   = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int CB   = COUNTER_BITS;

   btb_state_e            state_q, state_d;
   logic [INDEX_BITS-1:0] sweep_q, sweep_d;
   logic [WB-1:0]         rr_q [SETS];

   logic [INDEX_BITS-1:0] lk_idx, up_idx, w_idx;
   logic [TB-1:0]         lk_tag, up_tag;
   logic [WAYS-1:0]       lk_v, up_v, we;
   logic [TB-1:0]         lk_t [WAYS];
   logic [TB-1:0]         up_t [WAYS];
   logic [XLEN-1:0]       lk_tg [WAYS];
   logic [CB-1:0]         lk_c [WAYS];
   logic [CB-1:0]         up_c [WAYS];

   logic            hit, match, inv, acc, rr_adv;
   logic [XLEN-1:0] tgt_hit;
   logic [CB-1:0]   ctr_hit, m_ctr, new_ctr;
   logic [WB-1:0]   m_way, inv_way, sel;
   logic            unused;

   assign lk_idx = i_pc[INDEX_BITS+1:2];
   assign up_idx = i_update_pc[INDEX_BITS+1:2];
   assign lk_tag = {i_pc[XLEN-1:INDEX_BITS+2], i_pc[1]};
   assign up_tag = {i_update_pc[XLEN-1:INDEX_BITS+2], i_update_pc[1]};

   // Sweep FSM: flush (in either state) restarts at set 0; last set returns to IDLE.
   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      if (i_flush) begin
         state_d = SWEEP;
         sweep_d = '0;
      end else if (state_q == SWEEP) begin
         sweep_d = sweep_q + 1'b1;
         state_d = (&sweep_q) ? IDLE : SWEEP;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= SWEEP;
         sweep_q <= '0;
      end else begin
         state_q <= state_d;
         sweep_q <= sweep_d;
      end
   end

   assign o_busy = (state_q == SWEEP);
   assign acc    = i_update & ~o_busy;

   // Lookup: at most one way matches, so an OR-style select is sufficient.
   always_comb begin
      hit     = 1'b0;
      tgt_hit = '0;
      ctr_hit = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (lk_v[w] && lk_t[w] == lk_tag) begin
            hit     = 1'b1;
            tgt_hit = lk_tg[w];
            ctr_hit = lk_c[w];
         end
      end
   end

   assign o_btb_hit          = hit & ~o_busy;
   assign o_predicted_taken  = o_btb_hit & ctr_hit[CB-1];
   assign o_predicted_target = o_btb_hit ? tgt_hit : '0;

   // Victim select; descending scan so the lowest-index invalid way wins.
   always_comb begin
      match   = 1'b0;
      inv     = 1'b0;
      m_way   = '0;
      inv_way = '0;
      m_ctr   = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (up_v[w] && up_t[w] == up_tag) begin
            match = 1'b1;
            m_way = WB'(w);
            m_ctr = up_c[w];
         end
         if (!up_v[w]) begin
            inv     = 1'b1;
            inv_way = WB'(w);
         end
      end
   end

   assign sel     = match ? m_way : (inv ? inv_way : rr_q[up_idx]);
   assign new_ctr = match ? CB'(ctr_sat(4'(m_ctr), i_update_taken, CB))
                          : CB'(ctr_init(i_update_taken, CB));
   assign rr_adv  = acc & ~match & ~inv;
   assign w_idx   = o_busy ? sweep_q : up_idx;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
      end else if (rr_adv) begin
         rr_q[up_idx] <= (WAYS == 1) ? '0 : WB'(rr_q[up_idx] + WB'(1));
      end
   end

   for (genvar g = 0; g < WAYS; g++) begin : g_way
      assign we[g] = o_busy | (acc & (sel == WB'(g)));
      btb_set_assoc_way #(
         .XLEN(XLEN), .INDEX_BITS(INDEX_BITS), .TAG_BITS(TB), .COUNTER_BITS(CB)
      ) u_way (
         .i_clk      (i_clk),
         .i_lk_idx   (lk_idx),
         .o_lk_valid (lk_v[g]),
         .o_lk_tag   (lk_t[g]),
         .o_lk_target(lk_tg[g]),
         .o_lk_ctr   (lk_c[g]),
         .i_up_idx   (up_idx),
         .o_up_valid (up_v[g]),
         .o_up_tag   (up_t[g]),
         .o_up_ctr   (up_c[g]),
         .i_we       (we[g]),
         .i_w_idx    (w_idx),
         .i_w_valid  (~o_busy),
         .i_w_tag    (up_tag),
         .i_w_target (i_update_target),
         .i_w_ctr    (new_ctr)
      );
   end

`ifdef BTB_PERF_EN
   logic [31:0] perf_lk_q, perf_hit_q, perf_up_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         perf_lk_q  <= '0;
         perf_hit_q <= '0;
         perf_up_q  <= '0;
      end else if (!o_busy) begin
         perf_lk_q  <= perf_lk_q + 32'd1;
         perf_hit_q <= perf_hit_q + 32'(o_btb_hit);
         perf_up_q  <= perf_up_q + 32'(acc);
      end
   end

   assign o_perf_lookups = perf_lk_q;
   assign o_perf_hits    = perf_hit_q;
   assign o_perf_updates = perf_up_q;
`endif

   // PC bit 0 never participates; only the counter MSB drives the prediction.
   assign unused = ^{i_pc[0], i_update_pc[0], ctr_hit};

endmodule

// File: tb/tb_btb_set_assoc.sv
// tb_btb_set_assoc: randomized + directed scoreboard bench against a behavioural BTB model
module tb_btb_set_assoc;
   localparam int XLEN = 32, IB = 5, WAYS = 2, CB = 2;
   localparam int SETS = 1 << IB;
   localparam int HALF = 1 << (CB - 1);
   localparam int CMAX = (1 << CB) - 1;

   logic            clk = 0, rst = 1, flush = 0, upd = 0, utaken = 0;
   logic            busy, hit, ptaken;
   logic [31:0]     pc = 0, upc = 0, utgt = 0, ptgt;
`ifdef BTB_PERF_EN
   logic [31:0]     pl, ph, pu;
`endif

   int total = 0, bad = 0;

   always #5 clk = ~clk;

   btb_set_assoc #(.XLEN(XLEN), .INDEX_BITS(IB), .WAYS(WAYS), .COUNTER_BITS(CB)) dut (
      .i_clk(clk), .i_rst(rst), .i_flush(flush), .o_busy(busy),
      .i_pc(pc), .o_btb_hit(hit), .o_predicted_taken(ptaken), .o_predicted_target(ptgt),
      .i_update(upd), .i_update_pc(upc), .i_update_target(utgt), .i_update_taken(utaken)
`ifdef BTB_PERF_EN
      , .o_perf_lookups(pl), .o_perf_hits(ph), .o_perf_updates(pu)
`endif
   );

   typedef struct {logic busy; logic hit; logic taken; logic [31:0] tgt;} exp_t;
   exp_t q[$];

   bit          m_v   [SETS][WAYS];
   logic [31:0] m_key [SETS][WAYS];
   logic [31:0] m_tgt [SETS][WAYS];
   int          m_c   [SETS][WAYS];
   int          m_rr  [SETS];
   int          busy_cnt;
   int          n_lk, n_hit, n_up;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
      end
   endtask

   function automatic int set_of(input logic [31:0] a);
      return int'((a / 4) % SETS);
   endfunction

   // Everything except the index field and bit 0 identifies a branch.
   function automatic logic [31:0] key_of(input logic [31:0] a);
      return (a / (SETS * 4)) * (SETS * 4) + (a & 32'd2);
   endfunction

   task automatic model_reset();
      for (int s = 0; s < SETS; s++) begin
         m_rr[s] = 0;
         for (int w = 0; w < WAYS; w++) m_v[s][w] = 0;
      end
      busy_cnt = SETS;
      n_lk = 0; n_hit = 0; n_up = 0;
   endtask

   task automatic model_invalidate();
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) m_v[s][w] = 0;
   endtask

   function automatic exp_t model_lookup(input logic [31:0] a, input bit b);
      exp_t e;
      int s;
      e.busy = b; e.hit = 0; e.taken = 0; e.tgt = 0;
      s = set_of(a);
      if (!b)
         for (int w = 0; w < WAYS; w++)
            if (m_v[s][w] && m_key[s][w] == key_of(a)) begin
               e.hit = 1; e.taken = (m_c[s][w] >= HALF); e.tgt = m_tgt[s][w];
            end
      return e;
   endfunction

   task automatic model_update(input logic [31:0] a, input logic [31:0] t, input logic tk);
      int s, way;
      bit found;
      s = set_of(a); way = -1; found = 0;
      for (int w = 0; w < WAYS; w++)
         if (m_v[s][w] && m_key[s][w] == key_of(a)) begin way = w; found = 1; end
      if (way < 0)
         for (int w = 0; w < WAYS; w++)
            if (!m_v[s][w] && way < 0) way = w;
      if (way < 0) begin
         way = m_rr[s];
         m_rr[s] = (m_rr[s] + 1) % WAYS;
      end
      if (found) m_c[s][way] = tk ? ((m_c[s][way] < CMAX) ? m_c[s][way] + 1 : CMAX)
                                  : ((m_c[s][way] > 0) ? m_c[s][way] - 1 : 0);
      else       m_c[s][way] = tk ? HALF : HALF - 1;
      m_v[s][way] = 1; m_key[s][way] = key_of(a); m_tgt[s][way] = t;
   endtask

   task automatic step(input logic [31:0] lpc, input logic u, input logic [31:0] up,
                       input logic [31:0] ut, input logic tk, input logic fl);
      exp_t e;
      bit b;
      @(posedge clk); #1;
      rst = 0; pc = lpc; upd = u; upc = up; utgt = ut; utaken = tk; flush = fl;
      b = (busy_cnt > 0);
`ifdef BTB_PERF_EN
      chk("perf_lookups", pl, n_lk);
      chk("perf_hits", ph, n_hit);
      chk("perf_updates", pu, n_up);
`endif
      e = model_lookup(lpc, b);
      q.push_back(e);
      if (!b) begin
         n_lk++;
         if (e.hit) n_hit++;
         if (u) n_up++;
      end
      if (u && !b) model_update(up, ut, tk);
      if (fl) begin
         busy_cnt = SETS;
         model_invalidate();
      end else if (busy_cnt > 0) busy_cnt--;
   endtask

   task automatic look(input logic [31:0] a);
      step(a, 0, 0, 0, 0, 0);
   endtask

   task automatic update(input logic [31:0] a, input logic [31:0] t, input logic tk);
      step(a, 1, a, t, tk, 0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1; upd = 0; flush = 0;
      model_reset();
   endtask

   task automatic wait_idle();
      while (busy_cnt > 0) look($urandom);
      look($urandom);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("busy", busy, e.busy);
         chk("hit", hit, e.hit);
         chk("taken", ptaken, e.taken);
         chk("target", ptgt, e.tgt);
      end
   end

   function automatic logic [31:0] rnd_pc();
      return ($urandom_range(0, 7) << (IB + 2)) | ($urandom_range(0, 3) << 2) | ($urandom_range(0, 1) << 1);
   endfunction

   initial begin
      model_reset();
      wait_idle();
      // first transactions and partial-tag miss
      update(32'h100, 32'h200, 1);
      look(32'h100);
      look(32'h102);
      // counter walk: taken x3 then not-taken x2 after a fresh reset
      do_reset();
      wait_idle();
      for (int i = 0; i < 5; i++) begin
         update(32'h100, 32'h200, i < 3);
         look(32'h100);
      end
      // same-set allocation and round-robin eviction
      do_reset();
      wait_idle();
      update(32'h100, 32'h300, 1);
      update(32'h1100, 32'h400, 1);
      update(32'h2100, 32'h500, 0);
      look(32'h100);
      look(32'h1100);
      look(32'h2100);
      update(32'h3100, 32'h600, 1);
      look(32'h1100);
      look(32'h2100);
      // flush with updates during the sweep, then reset at sweep cycle 10
      step(32'h100, 0, 0, 0, 0, 1);
      for (int i = 0; i < 10; i++) update(32'h104 + 4 * i, 32'h700, 1);
      do_reset();
      for (int i = 0; i < SETS + 2; i++) update(32'h100, 32'h800, 1);
      look(32'h100);
      look(32'h100);
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 999) == 0) do_reset();
         else step(rnd_pc(), $urandom_range(0, 1), rnd_pc(), $urandom, $urandom_range(0, 1),
                   $urandom_range(0, 299) == 0);
      end
      look(32'h0);
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("drain", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
